// File: rtl/imem_port_arbiter.sv
// Shares one instruction-memory port between NUM_REQ fetch requesters and the ISP.
// Reads are granted round-robin, ISP writes win outright, one transaction in flight at a time.

module imem_port_lane #(
  parameter int IDX_W = 1,
  parameter int LANE  = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [IDX_W-1:0] owner,
  input  logic             grant_en,
  input  logic             resp_set,
  output logic             grant,
  output logic             resp_valid
);
  logic is_owner;

  assign is_owner = (owner == IDX_W'(LANE));
  assign grant    = grant_en & is_owner;

  always_ff @(posedge clock) begin
    if (reset) resp_valid <= 1'b0;
    else       resp_valid <= resp_set & is_owner;
  end
endmodule

module imem_port_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 20
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req_read,
  input  logic [NUM_REQ*ADDRESS_BITS-1:0] req_address,
  output logic [NUM_REQ-1:0]              req_grant,
  output logic [NUM_REQ-1:0]              resp_valid,
  output logic [DATA_WIDTH-1:0]           resp_data,
  output logic [ADDRESS_BITS-1:0]         resp_addr,
  input  logic                            isp_write,
  input  logic [ADDRESS_BITS-1:0]         isp_address,
  input  logic [DATA_WIDTH-1:0]           isp_data,
  output logic                            isp_ack,
  output logic                            mem_read,
  output logic                            mem_write,
  output logic [ADDRESS_BITS-1:0]         mem_address,
  output logic [DATA_WIDTH-1:0]           mem_in_data,
  input  logic                            mem_ready,
  input  logic                            mem_valid,
  input  logic [DATA_WIDTH-1:0]           mem_out_data,
  input  logic [ADDRESS_BITS-1:0]         mem_out_addr
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE_RD, WAIT_RD, ISSUE_WR} state_t;

  state_t                                 state;
  logic [IDX_W-1:0]                       last_grant;
  logic [IDX_W-1:0]                       owner;
  logic [IDX_W-1:0]                       winner;
  logic [IDX_W-1:0]                       cand;
  logic                                   any_req;
  logic                                   grant_en;
  logic                                   resp_set;
  logic [NUM_REQ-1:0][ADDRESS_BITS-1:0]   req_addr_arr;

  assign req_addr_arr = req_address;

  // Walk the requesters starting just after the last one served; first hit wins.
  always_comb begin
    winner  = last_grant;
    any_req = 1'b0;
    cand    = last_grant;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (cand == IDX_W'(NUM_REQ - 1)) ? '0 : cand + 1'b1;
      if (!any_req && req_read[cand]) begin
        any_req = 1'b1;
        winner  = cand;
      end
    end
  end

  assign grant_en = (state == ISSUE_RD) && mem_ready;
  assign isp_ack  = (state == ISSUE_WR) && mem_ready;
  // A response only counts while we are waiting for one; stray or post-reset data is dropped.
  assign resp_set = (state == WAIT_RD) && mem_valid;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      last_grant  <= IDX_W'(NUM_REQ - 1);
      owner       <= '0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_address <= '0;
      mem_in_data <= '0;
      resp_data   <= '0;
      resp_addr   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (isp_write) begin
            mem_address <= isp_address;
            mem_in_data <= isp_data;
            mem_write   <= 1'b1;
            state       <= ISSUE_WR;
          end else if (any_req) begin
            owner       <= winner;
            mem_address <= req_addr_arr[winner];
            mem_read    <= 1'b1;
            state       <= ISSUE_RD;
          end
        end
        ISSUE_WR: begin
          if (mem_ready) begin
            mem_write <= 1'b0;
            state     <= IDLE;
          end
        end
        ISSUE_RD: begin
          if (mem_ready) begin
            mem_read   <= 1'b0;
            last_grant <= owner;
            state      <= WAIT_RD;
          end
        end
        WAIT_RD: begin
          if (mem_valid) begin
            resp_data <= mem_out_data;
            resp_addr <= mem_out_addr;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    imem_port_lane #(
      .IDX_W (IDX_W),
      .LANE  (i)
    ) u_lane (
      .clock      (clock),
      .reset      (reset),
      .owner      (owner),
      .grant_en   (grant_en),
      .resp_set   (resp_set),
      .grant      (req_grant[i]),
      .resp_valid (resp_valid[i])
    );
  end
endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter: inputs change and outputs are sampled on the falling edge.
module tb_imem_port_arbiter;
  localparam int NUM_REQ = 2;
  localparam int DW      = 32;
  localparam int AB      = 20;

  logic                 clock = 1'b0;
  logic                 reset;
  logic [NUM_REQ-1:0]   req_read;
  logic [NUM_REQ*AB-1:0] req_address;
  logic [NUM_REQ-1:0]   req_grant;
  logic [NUM_REQ-1:0]   resp_valid;
  logic [DW-1:0]        resp_data;
  logic [AB-1:0]        resp_addr;
  logic                 isp_write;
  logic [AB-1:0]        isp_address;
  logic [DW-1:0]        isp_data;
  logic                 isp_ack;
  logic                 mem_read;
  logic                 mem_write;
  logic [AB-1:0]        mem_address;
  logic [DW-1:0]        mem_in_data;
  logic                 mem_ready;
  logic                 mem_valid;
  logic [DW-1:0]        mem_out_data;
  logic [AB-1:0]        mem_out_addr;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  imem_port_arbiter #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .ADDRESS_BITS(AB)) dut (
    .clock(clock), .reset(reset),
    .req_read(req_read), .req_address(req_address), .req_grant(req_grant),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_addr(resp_addr),
    .isp_write(isp_write), .isp_address(isp_address), .isp_data(isp_data), .isp_ack(isp_ack),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address), .mem_in_data(mem_in_data),
    .mem_ready(mem_ready), .mem_valid(mem_valid), .mem_out_data(mem_out_data), .mem_out_addr(mem_out_addr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  task automatic mem_rsp(input logic [DW-1:0] d, input logic [AB-1:0] a);
    mem_valid    = 1'b1;
    mem_out_data = d;
    mem_out_addr = a;
  endtask

  task automatic mem_idle();
    mem_valid    = 1'b0;
    mem_out_data = '0;
    mem_out_addr = '0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_grant"}, req_grant, 0);
    chk({tag, "_resp_valid"}, resp_valid, 0);
    chk({tag, "_resp_data"}, resp_data, 0);
    chk({tag, "_resp_addr"}, resp_addr, 0);
    chk({tag, "_isp_ack"}, isp_ack, 0);
    chk({tag, "_mem_rw"}, {mem_read, mem_write}, 0);
    chk({tag, "_mem_address"}, mem_address, 0);
    chk({tag, "_mem_in_data"}, mem_in_data, 0);
  endtask

  initial begin
    logic [AB-1:0] rr_addr [NUM_REQ];
    logic [1:0]    exp_oh;
    int            who;

    reset = 1'b1; req_read = '0; req_address = '0;
    isp_write = 1'b0; isp_address = '0; isp_data = '0;
    mem_ready = 1'b1; mem_idle();
    step(); step();
    check_all_zero("reset");
    reset = 1'b0;

    // Single read, zero-wait memory
    req_read = 2'b01; req_address[AB-1:0] = 20'h00010;
    step();
    chk("rd1_grant", req_grant, 2'b01);
    chk("rd1_mem_read", mem_read, 1);
    chk("rd1_mem_address", mem_address, 20'h00010);
    req_read = '0;
    step();
    chk("rd1_wait_no_read", mem_read, 0);
    chk("rd1_wait_no_resp", resp_valid, 0);
    mem_rsp(32'hDEADBEEF, 20'h00010);
    step();
    chk("rd1_resp_valid", resp_valid, 2'b01);
    chk("rd1_resp_data", resp_data, 32'hDEADBEEF);
    chk("rd1_resp_addr", resp_addr, 20'h00010);
    mem_idle();
    step();
    chk("rd1_resp_pulse", resp_valid, 0);

    // Round robin from a fresh reset: expect 0,1,0,1
    reset = 1'b1; step(); reset = 1'b0;
    rr_addr[0] = 20'h00100; rr_addr[1] = 20'h00200;
    req_address = {rr_addr[1], rr_addr[0]};
    req_read = 2'b11;
    for (int t = 0; t < 4; t++) begin
      who    = t % 2;
      exp_oh = (who == 0) ? 2'b01 : 2'b10;
      step();
      chk($sformatf("rr%0d_grant", t), req_grant, exp_oh);
      chk($sformatf("rr%0d_addr", t), mem_address, rr_addr[who]);
      step();
      mem_rsp(32'hA000_0000 + 32'(t), rr_addr[who]);
      step();
      chk($sformatf("rr%0d_resp_valid", t), resp_valid, exp_oh);
      chk($sformatf("rr%0d_resp_addr", t), resp_addr, rr_addr[who]);
      chk($sformatf("rr%0d_resp_data", t), resp_data, 32'hA000_0000 + 32'(t));
      mem_idle();
    end
    req_read = '0;
    step();

    // ISP write and read in the same IDLE cycle: write first
    isp_write = 1'b1; isp_address = 20'h00004; isp_data = 32'h12345678;
    req_read = 2'b10; req_address[2*AB-1:AB] = 20'h00300;
    step();
    chk("isp_mem_write", mem_write, 1);
    chk("isp_ack", isp_ack, 1);
    chk("isp_no_read", mem_read, 0);
    chk("isp_no_grant", req_grant, 0);
    chk("isp_mem_address", mem_address, 20'h00004);
    chk("isp_mem_in_data", mem_in_data, 32'h12345678);
    isp_write = 1'b0;
    step();
    chk("isp_ack_pulse", isp_ack, 0);
    chk("isp_idle_no_grant", req_grant, 0);
    step();
    chk("isp_then_rd_grant", req_grant, 2'b10);
    chk("isp_then_rd_addr", mem_address, 20'h00300);
    req_read = '0;
    step();
    mem_rsp(32'h0BADF00D, 20'h00300);
    step();
    chk("isp_then_rd_resp", resp_valid, 2'b10);
    mem_idle();

    // Backpressure: mem_ready low for 3 cycles of ISSUE_RD
    mem_ready = 1'b0;
    req_read = 2'b01; req_address[AB-1:0] = 20'h00400;
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("bp%0d_mem_read", c), mem_read, 1);
      chk($sformatf("bp%0d_addr", c), mem_address, 20'h00400);
      chk($sformatf("bp%0d_no_grant", c), req_grant, 0);
    end
    mem_ready = 1'b1;
    #1;
    chk("bp_grant_on_ready", req_grant, 2'b01);
    req_read = '0;
    step();
    chk("bp_grant_pulse", req_grant, 0);
    mem_rsp(32'h44440000, 20'h00400);
    step();
    chk("bp_resp", resp_valid, 2'b01);
    chk("bp_resp_data", resp_data, 32'h44440000);
    mem_idle();

    // Long latency with a competing request arriving during the wait
    req_read = 2'b01; req_address[AB-1:0] = 20'h00500;
    step();
    chk("ll_grant0", req_grant, 2'b01);
    req_read = 2'b10; req_address[2*AB-1:AB] = 20'h00600;
    req_read[0] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      chk($sformatf("ll_wait%0d_no_read", c), {mem_read, req_grant}, 0);
      chk($sformatf("ll_wait%0d_no_resp", c), resp_valid, 0);
    end
    mem_rsp(32'h55550000, 20'h00500);
    step();
    chk("ll_resp0", resp_valid, 2'b01);
    chk("ll_resp0_addr", resp_addr, 20'h00500);
    chk("ll_no_read_at_resp", mem_read, 0);
    mem_idle();
    step();
    chk("ll_grant1", req_grant, 2'b10);
    chk("ll_addr1", mem_address, 20'h00600);
    req_read = '0;
    step();
    mem_rsp(32'h66660000, 20'h00600);
    step();
    chk("ll_resp1", resp_valid, 2'b10);
    chk("ll_resp1_data", resp_data, 32'h66660000);
    mem_idle();

    // Reset while waiting for read data, then a late mem_valid
    req_read = 2'b01; req_address[AB-1:0] = 20'h00700;
    step();
    chk("rst_pre_grant", req_grant, 2'b01);
    req_read = '0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_all_zero("rst_mid");
    mem_rsp(32'hBAD0BAD0, 20'h00700);
    step();
    chk("rst_late_no_resp", resp_valid, 0);
    chk("rst_late_no_data", resp_data, 0);
    chk("rst_late_no_read", mem_read, 0);
    mem_idle();
    req_read = 2'b11; req_address = {20'h00900, 20'h00800};
    step();
    chk("rst_first_grant", req_grant, 2'b01);
    chk("rst_first_addr", mem_address, 20'h00800);
    req_read = '0;
    step();
    mem_rsp(32'h77770000, 20'h00800);
    step();
    chk("rst_first_resp", resp_valid, 2'b01);
    chk("rst_first_resp_data", resp_data, 32'h77770000);
    mem_idle();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
